// File: rtl/stack_push_seq.sv
// stack_push_seq
// Emits a 16-bit program counter (PCH then PCL), plus an optional status byte,
// as consecutive writes to stack page $01. It also owns the 6502 stack pointer.
// The instruction sequencer uses it for JSR, BRK, IRQ and NMI entry.
// Every output is decoded from registered state, so no input reaches an output
// combinationally.
module stack_push_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        push_p,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic        sp_load,
    input  logic [7:0]  sp_in,
    input  logic        rdy,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        rw,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sp
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PUSH_H = 3'd1,
        S_PUSH_L = 3'd2,
        S_PUSH_P = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] STACK_PAGE = 8'h01;
    localparam logic [7:0] SP_RESET   = 8'hFF;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_pc;
    logic [7:0]  r_p;
    logic        r_push_p;
    logic [7:0]  r_sp;

    logic        w_idle;
    logic        w_in_write;
    logic        w_advance;
    logic        w_accept;

    assign w_idle     = (r_state == S_IDLE);
    assign w_in_write = (r_state == S_PUSH_H) || (r_state == S_PUSH_L) ||
                        (r_state == S_PUSH_P);
    // A write cycle completes only when the bus is ready; otherwise it repeats.
    assign w_advance  = w_in_write && rdy;
    // start is honoured only in IDLE. It wins over sp_load in the same cycle.
    assign w_accept   = w_idle && start;

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: walk PCH -> PCL -> (P) -> DONE, holding while rdy is low.
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_PUSH_H;
                end
            end
            S_PUSH_H: begin
                if (rdy) begin
                    w_next_state = S_PUSH_L;
                end
            end
            S_PUSH_L: begin
                if (rdy) begin
                    w_next_state = r_push_p ? S_PUSH_P : S_DONE;
                end
            end
            S_PUSH_P: begin
                if (rdy) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture the push operands when a sequence is accepted. They stay frozen until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= 16'h0000;
            r_p      <= 8'h00;
            r_push_p <= 1'b0;
        end else if (w_accept) begin
            r_pc     <= pc_in;
            r_p      <= p_in;
            r_push_p <= push_p;
        end
    end

    // Stack pointer: TXS-style load in IDLE, and a post-decrement on each completed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= SP_RESET;
        end else if (w_idle && sp_load && !start) begin
            r_sp <= sp_in;
        end else if (w_advance) begin
            // 8-bit arithmetic wraps $00 to $FF, so the address stays in page $01.
            r_sp <= r_sp - 8'd1;
        end
    end

    // Bus outputs, decoded from the state and the captured operands only.
    always_comb begin
        addr     = 16'h0000;
        data_out = 8'h00;
        rw       = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_PUSH_H: begin
                addr     = {STACK_PAGE, r_sp};
                data_out = r_pc[15:8];
                rw       = 1'b0;
                busy     = 1'b1;
            end
            S_PUSH_L: begin
                addr     = {STACK_PAGE, r_sp};
                data_out = r_pc[7:0];
                rw       = 1'b0;
                busy     = 1'b1;
            end
            S_PUSH_P: begin
                addr     = {STACK_PAGE, r_sp};
                data_out = r_p;
                rw       = 1'b0;
                busy     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                addr = 16'h0000;
            end
        endcase
    end

    assign sp = r_sp;

endmodule

// File: tb/tb_stack_push_seq.sv
// Directed testbench for stack_push_seq.
// A table of per-cycle records holds the inputs to drive before a rising edge
// and the outputs expected just after that edge. Hand-written sequences cover
// reset at power-up and reset in the middle of a push.
module tb_stack_push_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        push_p;
    logic [15:0] pc_in;
    logic [7:0]  p_in;
    logic        sp_load;
    logic [7:0]  sp_in;
    logic        rdy;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        rw;
    logic        busy;
    logic        done;
    logic [7:0]  sp;

    int n_checks;
    int n_errors;

    typedef struct {
        string       name;
        logic        start;
        logic        push_p;
        logic [15:0] pc_in;
        logic [7:0]  p_in;
        logic        sp_load;
        logic [7:0]  sp_in;
        logic        rdy;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_rw;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_sp;
    } vec_t;

    vec_t vecs[$];

    stack_push_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .push_p   (push_p),
        .pc_in    (pc_in),
        .p_in     (p_in),
        .sp_load  (sp_load),
        .sp_in    (sp_in),
        .rdy      (rdy),
        .addr     (addr),
        .data_out (data_out),
        .rw       (rw),
        .busy     (busy),
        .done     (done),
        .sp       (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name,
                                input logic st, input logic pp, input logic [15:0] pc,
                                input logic [7:0] p, input logic sl, input logic [7:0] si,
                                input logic ry,
                                input logic [15:0] ea, input logic [7:0] ed, input logic erw,
                                input logic eb, input logic edn, input logic [7:0] esp);
        vec_t v;
        v.name = name; v.start = st; v.push_p = pp; v.pc_in = pc; v.p_in = p;
        v.sp_load = sl; v.sp_in = si; v.rdy = ry;
        v.e_addr = ea; v.e_data = ed; v.e_rw = erw; v.e_busy = eb; v.e_done = edn; v.e_sp = esp;
        return v;
    endfunction

    task automatic check_outputs(input string name, input logic [15:0] ea, input logic [7:0] ed,
                                 input logic erw, input logic eb, input logic edn,
                                 input logic [7:0] esp);
        check({name, ".addr"}, addr, ea);
        check({name, ".data"}, {8'h00, data_out}, {8'h00, ed});
        check({name, ".rw"},   {15'h0, rw},   {15'h0, erw});
        check({name, ".busy"}, {15'h0, busy}, {15'h0, eb});
        check({name, ".done"}, {15'h0, done}, {15'h0, edn});
        check({name, ".sp"},   {8'h00, sp},   {8'h00, esp});
    endtask

    // Drive one record, clock it in, and compare just after the edge.
    task automatic run_vec(input vec_t v);
        start   = v.start;
        push_p  = v.push_p;
        pc_in   = v.pc_in;
        p_in    = v.p_in;
        sp_load = v.sp_load;
        sp_in   = v.sp_in;
        rdy     = v.rdy;
        @(posedge clk);
        #1;
        check_outputs(v.name, v.e_addr, v.e_data, v.e_rw, v.e_busy, v.e_done, v.e_sp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset with random inputs on every pin.
        rst_n   = 1'b0;
        start   = 1'($urandom);
        push_p  = 1'($urandom);
        pc_in   = 16'($urandom);
        p_in    = 8'($urandom);
        sp_load = 1'($urandom);
        sp_in   = 8'($urandom);
        rdy     = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF);
        start   = 1'b0;
        sp_load = 1'b0;
        rdy     = 1'b1;
        #2;
        rst_n = 1'b1;

        //        name          st pp  pc       p      sl  si     rdy  addr      data   rw  bsy dn  sp
        // JSR push: 2 bytes, done in cycle N+3.
        vecs.push_back(mk("jsr_txs",  0, 0, 16'h0000, 8'h00, 1, 8'hFD, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFD));
        vecs.push_back(mk("jsr_h",    1, 0, 16'hC0A2, 8'h00, 0, 8'h00, 1, 16'h01FD, 8'hC0, 0, 1, 0, 8'hFD));
        vecs.push_back(mk("jsr_l",    0, 1, 16'hFFFF, 8'hFF, 0, 8'h00, 1, 16'h01FC, 8'hA2, 0, 1, 0, 8'hFC));
        vecs.push_back(mk("jsr_done", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 1, 8'hFB));
        vecs.push_back(mk("jsr_idle", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFB));
        // BRK push with SP wrapping $00 -> $FF.
        vecs.push_back(mk("brk_txs",  0, 0, 16'h0000, 8'h00, 1, 8'h01, 1, 16'h0000, 8'h00, 1, 0, 0, 8'h01));
        vecs.push_back(mk("brk_h",    1, 1, 16'h1234, 8'hB4, 0, 8'h00, 1, 16'h0101, 8'h12, 0, 1, 0, 8'h01));
        vecs.push_back(mk("brk_l",    0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0100, 8'h34, 0, 1, 0, 8'h00));
        vecs.push_back(mk("brk_p",    0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01FF, 8'hB4, 0, 1, 0, 8'hFF));
        vecs.push_back(mk("brk_done", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 1, 8'hFE));
        vecs.push_back(mk("brk_idle", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFE));
        // start and sp_load together: start wins and the load is dropped.
        vecs.push_back(mk("prio_h",   1, 0, 16'h5566, 8'h00, 1, 8'h40, 1, 16'h01FE, 8'h55, 0, 1, 0, 8'hFE));
        vecs.push_back(mk("prio_l",   0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01FD, 8'h66, 0, 1, 0, 8'hFD));
        vecs.push_back(mk("prio_done",0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 1, 8'hFC));
        vecs.push_back(mk("prio_idle",0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFC));
        // RDY stall: two low cycles during PUSH_L, done in cycle N+5.
        vecs.push_back(mk("stl_txs",  0, 0, 16'h0000, 8'h00, 1, 8'hFD, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFD));
        vecs.push_back(mk("stl_h",    1, 0, 16'hC0A2, 8'h00, 0, 8'h00, 1, 16'h01FD, 8'hC0, 0, 1, 0, 8'hFD));
        vecs.push_back(mk("stl_l",    0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01FC, 8'hA2, 0, 1, 0, 8'hFC));
        vecs.push_back(mk("stl_hold1",0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h01FC, 8'hA2, 0, 1, 0, 8'hFC));
        vecs.push_back(mk("stl_hold2",0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 16'h01FC, 8'hA2, 0, 1, 0, 8'hFC));
        vecs.push_back(mk("stl_done", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 1, 8'hFB));
        vecs.push_back(mk("stl_idle", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFB));
        // start/sp_load pulses during PUSH_L and DONE are ignored.
        vecs.push_back(mk("ign_h",    1, 1, 16'hABCD, 8'h5A, 0, 8'h00, 1, 16'h01FB, 8'hAB, 0, 1, 0, 8'hFB));
        vecs.push_back(mk("ign_l",    0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01FA, 8'hCD, 0, 1, 0, 8'hFA));
        vecs.push_back(mk("ign_p",    1, 0, 16'h0000, 8'h00, 1, 8'h00, 1, 16'h01F9, 8'h5A, 0, 1, 0, 8'hF9));
        vecs.push_back(mk("ign_done", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 1, 8'hF8));
        vecs.push_back(mk("ign_idle", 1, 1, 16'h7777, 8'h77, 1, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hF8));
        vecs.push_back(mk("ign_quiet",0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hF8));

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of PUSH_L takes effect without waiting for a clock edge.
        run_vec(mk("mid_h", 1, 0, 16'h2222, 8'h00, 0, 8'h00, 1, 16'h01F8, 8'h22, 0, 1, 0, 8'hF8));
        run_vec(mk("mid_l", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01F7, 8'h22, 0, 1, 0, 8'hF7));
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("mid_rst", 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF);
        @(posedge clk);
        #1;
        check_outputs("mid_rst_hold", 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF);
        rst_n = 1'b1;

        // After the reset is released, a fresh 3-byte push runs from SP = $FF.
        run_vec(mk("post_h",    1, 1, 16'h8001, 8'h33, 0, 8'h00, 1, 16'h01FF, 8'h80, 0, 1, 0, 8'hFF));
        run_vec(mk("post_l",    0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01FE, 8'h01, 0, 1, 0, 8'hFE));
        run_vec(mk("post_p",    0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h01FD, 8'h33, 0, 1, 0, 8'hFD));
        run_vec(mk("post_done", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 1, 8'hFC));
        run_vec(mk("post_idle", 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00, 1, 0, 0, 8'hFC));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stack_push_seq.md
# stack_push_seq

Serializes a 16-bit program counter, plus an optional status byte, onto the 6502 8-bit data bus as a sequence of stack writes. It is the write-side counterpart of the byte-wise address latch: that latch assembles PCL/PCH from the bus, and this block emits PCH/PCL/P to page $01. It sits between the instruction sequencer and the bus interface, and is used for JSR, BRK, IRQ and NMI entry. It owns the stack pointer register.

## Interface
- No parameters. Stack page is fixed at $01.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a push sequence; sampled only in IDLE.
- `push_p`  in  1  sampled with `start`; 1 = also push the status byte after PCL.
- `pc_in`  in  16  value to push; sampled with `start`.
- `p_in`  in  8  status byte; sampled with `start`.
- `sp_load`  in  1  load `sp_in` into SP; honoured only in IDLE.
- `sp_in`  in  8  new stack pointer value (TXS).
- `rdy`  in  1  bus ready. When 0, the current write cycle is held.
- `addr`  out  16  bus address.
- `data_out`  out  8  bus write data.
- `rw`  out  1  1 = read/idle, 0 = write.
- `busy`  out  1  high in any write state.
- `done`  out  1  one-cycle pulse after the last write completes.
- `sp`  out  8  current stack pointer.

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, DONE.
- Reset values: state = IDLE, `sp` = $FF, `addr` = $0000, `data_out` = $00, `rw` = 1, `busy` = 0, `done` = 0, internal captures = 0.
- IDLE outputs: `addr` = $0000, `data_out` = $00, `rw` = 1.
- IDLE, `start` = 1:
  - Capture `pc_in`, `p_in`, `push_p`.
  - Go to PUSH_H.
  - `start` takes priority over `sp_load` in the same cycle; `sp_load` is then ignored.
- IDLE, `sp_load` = 1, `start` = 0: SP <= `sp_in`. State stays IDLE.
- PUSH_H: `addr` = {$01, SP}, `data_out` = PC[15:8], `rw` = 0.
- PUSH_L: same address form, `data_out` = PC[7:0], `rw` = 0.
- PUSH_P: same address form, `data_out` = P, `rw` = 0.
- Leaving a write state with `rdy` = 1:
  - SP <= SP − 1, modulo 256 ($00 wraps to $FF; the address stays in page $01).
  - PUSH_H → PUSH_L.
  - PUSH_L → PUSH_P if the captured `push_p` is 1, else DONE.
  - PUSH_P → DONE.
- Write state with `rdy` = 0: state, SP and all outputs hold. The write repeats with identical `addr`/`data_out`.
- DONE: `done` = 1, `rw` = 1, `addr` = $0000. Next state is IDLE unconditionally.
- `start` outside IDLE (including DONE) is ignored, not queued.
- `sp_load` outside IDLE is ignored.
- Captured values are stable for the whole sequence; changes on `pc_in`/`p_in` after capture have no effect.
- `rst_n` low mid-sequence: all outputs and state go to reset values immediately (asynchronously). A partial sequence is abandoned.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- `start` high at edge N → PUSH_H drives the bus during cycle N+1.
- With `rdy` = 1 throughout:
  - 3-byte push: PUSH_H, PUSH_L, PUSH_P occupy cycles N+1..N+3. `done` is high in cycle N+4. IDLE from N+5, so a new `start` is accepted at edge N+5.
  - 2-byte push: PUSH_H, PUSH_L occupy cycles N+1..N+2. `done` is high in cycle N+3.
- Each low `rdy` cycle in a write state adds exactly one cycle of latency.
- `sp` output updates on the edge that leaves each write state. It equals the final SP (entry SP − 2 or − 3) in the DONE cycle.

## Test plan
- Reset: assert `rst_n` = 0 with random inputs → `sp` = $FF, `rw` = 1, `addr` = $0000, `busy` = 0, `done` = 0.
- JSR push: `sp_load` with `sp_in` = $FD, then `start` with `pc_in` = $C0A2, `push_p` = 0 → writes $C0 @ $01FD, then $A2 @ $01FC; `done` in cycle N+3; final `sp` = $FB.
- BRK push with wrap: SP = $01, `pc_in` = $1234, `p_in` = $B4, `push_p` = 1 → writes $12 @ $0101, $34 @ $0100, $B4 @ $01FF; final `sp` = $FE.
- RDY stall: same as the JSR case with `rdy` = 0 for 2 cycles during PUSH_L → $A2 @ $01FC held for 3 cycles; `sp` does not decrement during the stall; `done` in cycle N+5.
- Ignored requests: pulse `start` and `sp_load` (`sp_in` = $00) during PUSH_L and during DONE → sequence and SP are unaffected; no second sequence starts.
- Reset mid-op: drop `rst_n` during PUSH_L → `rw` = 1, `sp` = $FF immediately; after release, a fresh `start` runs a full, correct sequence.
